// File: rtl/xfer_sched_pkg.sv
// Shared definitions for the transfer scheduler: transfer-FSM state codes,
// scheduler state encoding and default parameter values.
package xfer_sched_pkg;

  localparam int DEF_MAX_PEND = 8;
  localparam int DEF_TMO_CYC  = 1023;
  localparam int DEF_GAP_CYC  = 2;

  localparam int PEND_W = 4;
  localparam int WDOG_W = 12;
  localparam int GAP_W  = 3;

  // State codes reported by the downstream sample-transfer FSM
  typedef enum logic [2:0] {
    XS_IDLE       = 3'b000,
    XS_INC_CHAN   = 3'b001,
    XS_L1A_RD_TWO = 3'b010,
    XS_RD_ENA     = 3'b011,
    XS_STRT_TRNS  = 3'b100,
    XS_WAIT       = 3'b101
  } xstate_e;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_WAIT_DONE  = 3'd3,
    S_GAP        = 3'd4
  } sched_state_e;

endpackage

// File: rtl/xfer_pend_cnt.sv
// Saturating pending-event counter with sticky overflow flag.
// Simultaneous inc and dec cancel out; clr wins over everything.
module xfer_pend_cnt
  import xfer_sched_pkg::*;
#(
  parameter int MAX_PEND = DEF_MAX_PEND
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              inc,
  input  logic              dec,
  input  logic              clr,
  output logic [PEND_W-1:0] count,
  output logic              ovfl
);

  localparam logic [PEND_W-1:0] CNT_MAX = PEND_W'(MAX_PEND);

  logic [PEND_W-1:0] count_q, count_d;
  logic              ovfl_q, ovfl_d;

  always_comb begin
    count_d = count_q;
    ovfl_d  = ovfl_q;
    if (clr) begin
      count_d = '0;
      ovfl_d  = 1'b0;
    end else if (inc && !dec) begin
      if (count_q == CNT_MAX) ovfl_d = 1'b1;
      else                    count_d = count_q + PEND_W'(1);
    end else if (dec && !inc) begin
      if (count_q != '0) count_d = count_q - PEND_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
      ovfl_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      ovfl_q  <= ovfl_d;
    end
  end

  assign count = count_q;
  assign ovfl  = ovfl_q;

endmodule

// File: rtl/xfer_sched.sv
// Transfer scheduler: queues L1A events and hands them one at a time to the
// sample-transfer FSM, with a per-transfer watchdog and an enforced idle gap.
module xfer_sched
  import xfer_sched_pkg::*;
#(
  parameter int MAX_PEND = DEF_MAX_PEND,
  parameter int TMO_CYC  = DEF_TMO_CYC,
  parameter int GAP_CYC  = DEF_GAP_CYC
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              L1A_EVT,
  input  logic              JTAG_MODE,
  input  logic              CLR_STAT,
  input  logic [2:0]        XSTATE,
  output logic              RDY,
  output logic [PEND_W-1:0] EVT_PEND,
  output logic              BUSY,
  output logic              XFER_DONE,
  output logic              OVFL,
  output logic              TIMEOUT
);

  localparam logic [WDOG_W-1:0] TMO_LIM  = WDOG_W'(TMO_CYC - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = (GAP_CYC == 0) ? '0 : GAP_W'(GAP_CYC - 1);

  sched_state_e      state_q, state_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              rdy_q, rdy_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              tmo_q, tmo_d;
  logic              inc, dec, tmo_evt;

  xfer_pend_cnt #(.MAX_PEND(MAX_PEND)) u_pend (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (inc),
    .dec   (dec),
    .clr   (CLR_STAT),
    .count (EVT_PEND),
    .ovfl  (OVFL)
  );

  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    gap_d   = gap_q;
    rdy_d   = 1'b0;
    done_d  = 1'b0;
    dec     = 1'b0;
    tmo_evt = 1'b0;
    inc     = L1A_EVT && !JTAG_MODE;
    case (state_q)
      S_IDLE: begin
        // RDY is registered on entry so it is high exactly during ISSUE
        if (EVT_PEND != '0 && !JTAG_MODE) begin
          state_d = S_ISSUE;
          rdy_d   = 1'b1;
        end
      end
      S_ISSUE: begin
        wdog_d  = '0;
        state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (XSTATE != XS_IDLE) begin
          state_d = S_WAIT_DONE;
          wdog_d  = '0;
        end else if (wdog_q == TMO_LIM) begin
          tmo_evt = 1'b1;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      S_WAIT_DONE: begin
        if (XSTATE == XS_IDLE) begin
          done_d  = 1'b1;
          dec     = 1'b1;
          state_d = S_GAP;
          gap_d   = '0;
        end else if (wdog_q == TMO_LIM) begin
          tmo_evt = 1'b1;
        end else begin
          wdog_d = wdog_q + WDOG_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) state_d = S_IDLE;
        else                   gap_d   = gap_q + GAP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // A watchdog expiry discards the event silently and still honours the gap
    if (tmo_evt) begin
      dec     = 1'b1;
      state_d = S_GAP;
      gap_d   = '0;
    end
    tmo_d  = CLR_STAT ? 1'b0 : (tmo_q || tmo_evt);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      wdog_q  <= '0;
      gap_q   <= '0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      gap_q   <= gap_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
    end
  end

  assign RDY       = rdy_q;
  assign XFER_DONE = done_q;
  assign BUSY      = busy_q;
  assign TIMEOUT   = tmo_q;

endmodule

// File: tb/tb_xfer_sched.sv
// Directed testbench for xfer_sched with default parameters
// (MAX_PEND=8, TMO_CYC=1023, GAP_CYC=2).
module tb_xfer_sched;
  import xfer_sched_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       L1A_EVT = 1'b0;
  logic       JTAG_MODE = 1'b0;
  logic       CLR_STAT = 1'b0;
  logic [2:0] XSTATE = 3'b000;
  logic       RDY, BUSY, XFER_DONE, OVFL, TIMEOUT;
  logic [3:0] EVT_PEND;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int rdy_cnt = 0;
  int done_cnt = 0;

  xfer_sched dut (
    .CLK       (CLK),
    .RST       (RST),
    .L1A_EVT   (L1A_EVT),
    .JTAG_MODE (JTAG_MODE),
    .CLR_STAT  (CLR_STAT),
    .XSTATE    (XSTATE),
    .RDY       (RDY),
    .EVT_PEND  (EVT_PEND),
    .BUSY      (BUSY),
    .XFER_DONE (XFER_DONE),
    .OVFL      (OVFL),
    .TIMEOUT   (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RDY === 1'b1) rdy_cnt++;
    if (XFER_DONE === 1'b1) done_cnt++;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic test_reset();
    int r0;
    RST = 1'b1;
    run(3);
    total_cnt++; if (RDY !== 1'b0) $display("FAIL reset_rdy: got %b want 0", RDY); else pass_cnt++;
    total_cnt++; if (EVT_PEND !== 4'd0) $display("FAIL reset_pend: got %0d want 0", EVT_PEND); else pass_cnt++;
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL reset_busy: got %b want 0", BUSY); else pass_cnt++;
    total_cnt++; if (XFER_DONE !== 1'b0) $display("FAIL reset_done: got %b want 0", XFER_DONE); else pass_cnt++;
    total_cnt++; if (OVFL !== 1'b0) $display("FAIL reset_ovfl: got %b want 0", OVFL); else pass_cnt++;
    total_cnt++; if (TIMEOUT !== 1'b0) $display("FAIL reset_timeout: got %b want 0", TIMEOUT); else pass_cnt++;
    RST = 1'b0;
    r0 = rdy_cnt;
    run(6);
    total_cnt++; if (rdy_cnt !== r0) $display("FAIL reset_no_rdy: got %0d RDY pulses want 0", rdy_cnt - r0); else pass_cnt++;
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", BUSY); else pass_cnt++;
    $display("test_reset done at cycle %0d", cyc);
  endtask

  task automatic test_single();
    L1A_EVT = 1'b1;
    step();
    L1A_EVT = 1'b0;
    total_cnt++; if (EVT_PEND !== 4'd1) $display("FAIL single_pend1: got %0d want 1", EVT_PEND); else pass_cnt++;
    total_cnt++; if (RDY !== 1'b0) $display("FAIL single_rdy_early: got %b want 0 at n+1", RDY); else pass_cnt++;
    step();
    total_cnt++; if (RDY !== 1'b1) $display("FAIL single_rdy_n2: got %b want 1 at n+2", RDY); else pass_cnt++;
    total_cnt++; if (BUSY !== 1'b1) $display("FAIL single_busy: got %b want 1", BUSY); else pass_cnt++;
    step();
    total_cnt++; if (RDY !== 1'b0) $display("FAIL single_rdy_width: got %b want 0 at n+3", RDY); else pass_cnt++;
    step();
    XSTATE = XS_WAIT;
    run(26);
    total_cnt++; if (XFER_DONE !== 1'b0) $display("FAIL single_done_early: got %b want 0", XFER_DONE); else pass_cnt++;
    XSTATE = XS_IDLE;
    step();
    total_cnt++; if (XFER_DONE !== 1'b1) $display("FAIL single_done: got %b want 1", XFER_DONE); else pass_cnt++;
    total_cnt++; if (EVT_PEND !== 4'd0) $display("FAIL single_pend0: got %0d want 0", EVT_PEND); else pass_cnt++;
    step();
    total_cnt++; if (XFER_DONE !== 1'b0) $display("FAIL single_done_width: got %b want 0", XFER_DONE); else pass_cnt++;
    total_cnt++; if (BUSY !== 1'b1) $display("FAIL single_gap_busy: got %b want 1", BUSY); else pass_cnt++;
    step();
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL single_idle: got %b want 0 after gap", BUSY); else pass_cnt++;
    $display("test_single done at cycle %0d", cyc);
  endtask

  task automatic test_overflow();
    XSTATE = XS_WAIT;
    for (int i = 0; i < 8; i++) begin
      L1A_EVT = 1'b1;
      step();
    end
    L1A_EVT = 1'b0;
    total_cnt++; if (EVT_PEND !== 4'd8) $display("FAIL ovfl_pend8: got %0d want 8", EVT_PEND); else pass_cnt++;
    total_cnt++; if (OVFL !== 1'b0) $display("FAIL ovfl_at_max: got %b want 0", OVFL); else pass_cnt++;
    L1A_EVT = 1'b1;
    step();
    L1A_EVT = 1'b0;
    total_cnt++; if (EVT_PEND !== 4'd8) $display("FAIL ovfl_sat: got %0d want 8", EVT_PEND); else pass_cnt++;
    total_cnt++; if (OVFL !== 1'b1) $display("FAIL ovfl_set: got %b want 1", OVFL); else pass_cnt++;
    CLR_STAT = 1'b1;
    step();
    CLR_STAT = 1'b0;
    total_cnt++; if (EVT_PEND !== 4'd0) $display("FAIL ovfl_clr_pend: got %0d want 0", EVT_PEND); else pass_cnt++;
    total_cnt++; if (OVFL !== 1'b0) $display("FAIL ovfl_clr_flag: got %b want 0", OVFL); else pass_cnt++;
    L1A_EVT = 1'b1;
    run(2);
    total_cnt++; if (EVT_PEND !== 4'd2) $display("FAIL clr_prio_pre: got %0d want 2", EVT_PEND); else pass_cnt++;
    CLR_STAT = 1'b1;
    step();
    CLR_STAT = 1'b0;
    L1A_EVT = 1'b0;
    total_cnt++; if (EVT_PEND !== 4'd0) $display("FAIL clr_prio: got %0d want 0", EVT_PEND); else pass_cnt++;
    XSTATE = XS_IDLE;
    step();
    total_cnt++; if (XFER_DONE !== 1'b1) $display("FAIL clr_mid_done: got %b want 1", XFER_DONE); else pass_cnt++;
    total_cnt++; if (EVT_PEND !== 4'd0) $display("FAIL clr_mid_floor: got %0d want 0", EVT_PEND); else pass_cnt++;
    run(5);
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL clr_mid_idle: got %b want 0", BUSY); else pass_cnt++;
    $display("test_overflow done at cycle %0d", cyc);
  endtask

  task automatic test_simul();
    XSTATE = XS_WAIT;
    for (int i = 0; i < 8; i++) begin
      L1A_EVT = 1'b1;
      step();
    end
    L1A_EVT = 1'b0;
    step();
    total_cnt++; if (EVT_PEND !== 4'd8) $display("FAIL simul_pre: got %0d want 8", EVT_PEND); else pass_cnt++;
    XSTATE = XS_IDLE;
    L1A_EVT = 1'b1;
    step();
    L1A_EVT = 1'b0;
    total_cnt++; if (XFER_DONE !== 1'b1) $display("FAIL simul_done: got %b want 1", XFER_DONE); else pass_cnt++;
    total_cnt++; if (EVT_PEND !== 4'd8) $display("FAIL simul_pend: got %0d want 8", EVT_PEND); else pass_cnt++;
    total_cnt++; if (OVFL !== 1'b0) $display("FAIL simul_ovfl: got %b want 0", OVFL); else pass_cnt++;
    CLR_STAT = 1'b1;
    step();
    CLR_STAT = 1'b0;
    run(4);
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL simul_idle: got %b want 0", BUSY); else pass_cnt++;
    $display("test_simul done at cycle %0d", cyc);
  endtask

  task automatic test_timeout();
    int d0;
    d0 = done_cnt;
    XSTATE = XS_IDLE;
    L1A_EVT = 1'b1;
    step();
    L1A_EVT = 1'b0;
    step();
    total_cnt++; if (RDY !== 1'b1) $display("FAIL tmo_rdy: got %b want 1", RDY); else pass_cnt++;
    run(1023);
    total_cnt++; if (TIMEOUT !== 1'b0) $display("FAIL tmo_early: got %b want 0", TIMEOUT); else pass_cnt++;
    total_cnt++; if (EVT_PEND !== 4'd1) $display("FAIL tmo_pend_hold: got %0d want 1", EVT_PEND); else pass_cnt++;
    step();
    total_cnt++; if (TIMEOUT !== 1'b1) $display("FAIL tmo_set: got %b want 1", TIMEOUT); else pass_cnt++;
    total_cnt++; if (EVT_PEND !== 4'd0) $display("FAIL tmo_pend_dec: got %0d want 0", EVT_PEND); else pass_cnt++;
    run(4);
    total_cnt++; if (done_cnt !== d0) $display("FAIL tmo_no_done: got %0d XFER_DONE pulses want 0", done_cnt - d0); else pass_cnt++;
    total_cnt++; if (TIMEOUT !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", TIMEOUT); else pass_cnt++;
    CLR_STAT = 1'b1;
    step();
    CLR_STAT = 1'b0;
    total_cnt++; if (TIMEOUT !== 1'b0) $display("FAIL tmo_clr: got %b want 0", TIMEOUT); else pass_cnt++;
    $display("test_timeout done at cycle %0d", cyc);
  endtask

  task automatic test_jtag();
    int r0;
    int ok;
    int rdy_cyc;
    int done_cyc;
    done_cyc = 0;
    JTAG_MODE = 1'b1;
    L1A_EVT = 1'b1;
    step();
    L1A_EVT = 1'b0;
    run(3);
    total_cnt++; if (EVT_PEND !== 4'd0) $display("FAIL jtag_ignore: got %0d want 0", EVT_PEND); else pass_cnt++;
    JTAG_MODE = 1'b0;
    XSTATE = XS_WAIT;
    for (int i = 0; i < 4; i++) begin
      L1A_EVT = 1'b1;
      step();
    end
    L1A_EVT = 1'b0;
    JTAG_MODE = 1'b1;
    run(2);
    XSTATE = XS_IDLE;
    step();
    total_cnt++; if (XFER_DONE !== 1'b1) $display("FAIL jtag_no_abort: got %b want 1", XFER_DONE); else pass_cnt++;
    total_cnt++; if (EVT_PEND !== 4'd3) $display("FAIL jtag_pend3: got %0d want 3", EVT_PEND); else pass_cnt++;
    r0 = rdy_cnt;
    run(20);
    total_cnt++; if (rdy_cnt !== r0) $display("FAIL jtag_holdoff: got %0d RDY pulses want 0", rdy_cnt - r0); else pass_cnt++;
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL jtag_hold_busy: got %b want 0", BUSY); else pass_cnt++;
    JTAG_MODE = 1'b0;
    for (int k = 0; k < 3; k++) begin
      ok = 0;
      for (int i = 0; i < 10 && ok == 0; i++) begin
        step();
        if (RDY === 1'b1) ok = 1;
      end
      rdy_cyc = cyc;
      total_cnt++; if (ok == 0) $display("FAIL jtag_rdy%0d: no RDY within 10 cycles, want a pulse", k); else pass_cnt++;
      if (k > 0) begin
        total_cnt++; if (rdy_cyc - done_cyc != 3) $display("FAIL jtag_gap%0d: got %0d cycles done->RDY want 3", k, rdy_cyc - done_cyc); else pass_cnt++;
      end
      XSTATE = XS_WAIT;
      run(3);
      XSTATE = XS_IDLE;
      ok = 0;
      for (int i = 0; i < 10 && ok == 0; i++) begin
        step();
        if (XFER_DONE === 1'b1) ok = 1;
      end
      done_cyc = cyc;
      total_cnt++; if (ok == 0) $display("FAIL jtag_done%0d: no XFER_DONE within 10 cycles, want a pulse", k); else pass_cnt++;
      $display("jtag transfer %0d: RDY at %0d, XFER_DONE at %0d, EVT_PEND=%0d", k, rdy_cyc, done_cyc, EVT_PEND);
    end
    run(6);
    total_cnt++; if (EVT_PEND !== 4'd0) $display("FAIL jtag_drained: got %0d want 0", EVT_PEND); else pass_cnt++;
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL jtag_final_idle: got %b want 0", BUSY); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int d0;
    int r0;
    XSTATE = XS_IDLE;
    L1A_EVT = 1'b1;
    step();
    L1A_EVT = 1'b0;
    step();
    total_cnt++; if (RDY !== 1'b1) $display("FAIL rmid_rdy: got %b want 1", RDY); else pass_cnt++;
    XSTATE = XS_WAIT;
    run(4);
    d0 = done_cnt;
    #2;
    RST = 1'b1;
    #1;
    total_cnt++; if (BUSY !== 1'b0) $display("FAIL rmid_busy: got %b want 0", BUSY); else pass_cnt++;
    total_cnt++; if (RDY !== 1'b0) $display("FAIL rmid_rdy0: got %b want 0", RDY); else pass_cnt++;
    total_cnt++; if (EVT_PEND !== 4'd0) $display("FAIL rmid_pend: got %0d want 0", EVT_PEND); else pass_cnt++;
    total_cnt++; if (OVFL !== 1'b0 || TIMEOUT !== 1'b0) $display("FAIL rmid_flags: got OVFL=%b TIMEOUT=%b want 0/0", OVFL, TIMEOUT); else pass_cnt++;
    XSTATE = XS_IDLE;
    run(2);
    total_cnt++; if (XFER_DONE !== 1'b0) $display("FAIL rmid_done: got %b want 0", XFER_DONE); else pass_cnt++;
    RST = 1'b0;
    r0 = rdy_cnt;
    run(6);
    total_cnt++; if (done_cnt !== d0) $display("FAIL rmid_no_done: got %0d XFER_DONE pulses want 0", done_cnt - d0); else pass_cnt++;
    total_cnt++; if (rdy_cnt !== r0) $display("FAIL rmid_no_rdy: got %0d RDY pulses want 0", rdy_cnt - r0); else pass_cnt++;
    $display("test_reset_mid done at cycle %0d", cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at cycle %0d, want finish", cyc);
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_simul();
    test_timeout();
    test_jtag();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
